run_controller: RTL and testbench



---
 rtl/run_controller.sv | 188 ++++++++++++++++++
 tb/tb_run_controller.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_controller.sv
`default_nettype none
// ============================================================================
// Module      : run_controller
// Description : Load / reset / run / halt sequencer around a single-cycle
//               processor. Streams a program into instruction memory, holds
//               the CPU in reset for a settle period, releases it, and stops
//               on the all-zero halt word while counting run cycles.
//               Optional watchdog: define RUN_CTRL_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module run_controller #(
    parameter int          ADDR_WIDTH     = 8,
    parameter int          RESET_CYCLES   = 20,
    parameter logic [31:0] WATCHDOG_LIMIT = 32'd100000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  rerun,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [31:0]           load_data,
    input  logic                  load_last,
    input  logic [31:0]           instruction,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  halted,
    output logic                  timeout,
    output logic [31:0]           cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_HOLD = 3'd2,
        S_RUN  = 3'd3,
        S_HALT = 3'd4
    } state_t;

    // Hold counter only needs to reach RESET_CYCLES-1.
    localparam int                    c_HOLD_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [c_HOLD_W-1:0]   c_HOLD_LAST = c_HOLD_W'(RESET_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] c_PTR_LAST  = '1;
    localparam logic [31:0]           c_HALT_WORD = 32'h0000_0000;
    localparam logic [31:0]           c_COUNT_MAX = 32'hFFFF_FFFF;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] w_ptr_next;
    logic [c_HOLD_W-1:0]   r_hold_cnt;
    logic [c_HOLD_W-1:0]   w_hold_next;
    logic [31:0]           r_cycle_count;
    logic [31:0]           w_cycle_next;
    logic [31:0]           w_cycle_inc;
    logic                  r_cpu_reset;
    logic                  w_accept;
`ifdef RUN_CTRL_WATCHDOG_EN
    logic                  r_timeout;
    logic                  w_timeout_next;
`endif

    assign w_accept    = load_valid & (r_state == S_LOAD);
    assign w_cycle_inc = (r_cycle_count == c_COUNT_MAX) ? r_cycle_count : r_cycle_count + 32'd1;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and next-datapath logic; every transition's side effects live here.
    always_comb begin
        w_state_next   = r_state;
        w_ptr_next     = r_ptr;
        w_hold_next    = r_hold_cnt;
        w_cycle_next   = r_cycle_count;
`ifdef RUN_CTRL_WATCHDOG_EN
        w_timeout_next = r_timeout;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_LOAD;
                    w_ptr_next   = '0;
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    // Pointer wraps to 0 after the last word; LOAD is left on that beat.
                    w_ptr_next = r_ptr + 1'b1;
                    if (load_last || (r_ptr == c_PTR_LAST)) begin
                        w_state_next = S_HOLD;
                        w_hold_next  = '0;
                    end
                end
            end
            S_HOLD: begin
                if (r_hold_cnt == c_HOLD_LAST) begin
                    w_state_next = S_RUN;
                    w_cycle_next = '0;
                end else begin
                    w_hold_next = r_hold_cnt + 1'b1;
                end
            end
            S_RUN: begin
                // The halt cycle itself is counted, so the increment always happens.
                w_cycle_next = w_cycle_inc;
                if (instruction == c_HALT_WORD) begin
                    w_state_next = S_HALT;
                end
`ifdef RUN_CTRL_WATCHDOG_EN
                else if (w_cycle_inc >= WATCHDOG_LIMIT) begin
                    w_state_next   = S_HALT;
                    w_timeout_next = 1'b1;
                end
`endif
            end
            S_HALT: begin
                if (start) begin
                    w_state_next   = S_LOAD;
                    w_ptr_next     = '0;
                    w_cycle_next   = '0;
`ifdef RUN_CTRL_WATCHDOG_EN
                    w_timeout_next = 1'b0;
`endif
                end else if (rerun) begin
                    w_state_next   = S_HOLD;
                    w_hold_next    = '0;
`ifdef RUN_CTRL_WATCHDOG_EN
                    w_timeout_next = 1'b0;
`endif
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath registers; cpu_reset is registered from the next state so it
    // toggles on exactly the edges that enter and leave RUN.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ptr         <= '0;
            r_hold_cnt    <= '0;
            r_cycle_count <= '0;
            r_cpu_reset   <= 1'b1;
        end else begin
            r_ptr         <= w_ptr_next;
            r_hold_cnt    <= w_hold_next;
            r_cycle_count <= w_cycle_next;
            r_cpu_reset   <= (w_state_next != S_RUN);
        end
    end

`ifdef RUN_CTRL_WATCHDOG_EN
    // Watchdog flag register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout_next;
        end
    end

    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

    assign load_ready  = (r_state == S_LOAD);
    assign imem_we     = w_accept;
    assign imem_addr   = r_ptr;
    assign imem_wdata  = load_data;
    assign cpu_reset   = r_cpu_reset;
    assign busy        = (r_state == S_LOAD) || (r_state == S_HOLD) || (r_state == S_RUN);
    assign halted      = (r_state == S_HALT);
    assign cycle_count = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_run_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_run_controller
// Description : Randomized self-checking bench for run_controller. A toy CPU
//               (PC counting from 0 while out of reset) fetches from a memory
//               filled by the DUT's write port; the expected run length is
//               computed from the program words the bench streamed in.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_run_controller;

    localparam int          AW    = 8;
    localparam int          DEPTH = 1 << AW;
    localparam int          RC    = 20;
    localparam logic [31:0] WD    = 32'd50;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          rerun;
    logic          load_valid;
    logic          load_ready;
    logic [31:0]   load_data;
    logic          load_last;
    logic [31:0]   instruction;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_reset;
    logic          busy;
    logic          halted;
    logic          timeout;
    logic [31:0]   cycle_count;

    logic [31:0]   dev_mem [DEPTH] = '{default: 32'h0};
    logic [31:0]   ref_mem [DEPTH] = '{default: 32'h0};
    logic [AW-1:0] pc = '0;
    logic [31:0]   prog [$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            n_writes = 0;

    always #5 clock = ~clock;

    run_controller #(
        .ADDR_WIDTH    (AW),
        .RESET_CYCLES  (RC),
        .WATCHDOG_LIMIT(WD)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .rerun      (rerun),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_last  (load_last),
        .instruction(instruction),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .halted     (halted),
        .timeout    (timeout),
        .cycle_count(cycle_count)
    );

    // Instruction memory and a processor that just walks the PC.
    always @(posedge clock) begin
        if (imem_we) begin
            dev_mem[imem_addr] <= imem_wdata;
            n_writes           <= n_writes + 1;
        end
        if (cpu_reset) pc <= '0;
        else           pc <= pc + 1'b1;
    end

    assign instruction = dev_mem[pc];

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Run length from the program alone: executing word k takes k+1 cycles;
    // the first zero word ends the run, otherwise the watchdog (if built) does.
    function automatic void expected_run(output logic [31:0] cnt, output logic to);
        cnt = 32'h0;
        to  = 1'b0;
        for (int k = 0; k < 4 * DEPTH; k++) begin
            if (ref_mem[k % DEPTH] == 32'h0) begin
                cnt = k + 1;
                return;
            end
`ifdef RUN_CTRL_WATCHDOG_EN
            if (k + 1 >= int'(WD)) begin
                cnt = WD;
                to  = 1'b1;
                return;
            end
`endif
        end
    endfunction

    function automatic logic [31:0] nz_word();
        return $urandom | 32'h1;
    endfunction

    // Pulse start (optionally with rerun), then stream prog[] with optional random gaps.
    task automatic load_program(input bit use_last, input bit gaps, input bit with_rerun);
        @(negedge clock);
        start      = 1'b1;
        rerun      = with_rerun;
        load_valid = 1'b1;
        load_data  = 32'hDEAD_BEEF;
        load_last  = 1'b0;
        #1;
        check_value("start_cycle_ready", load_ready, 1'b0);
        check_value("start_cycle_we", imem_we, 1'b0);
        @(negedge clock);
        start      = 1'b0;
        rerun      = 1'b0;
        load_valid = 1'b0;
        #1;
        check_value("load_ready", load_ready, 1'b1);
        check_value("load_cpu_reset", cpu_reset, 1'b1);
        for (int i = 0; i < prog.size(); i++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                load_valid = 1'b0;
                #1;
                check_value("gap_we", imem_we, 1'b0);
                @(negedge clock);
            end
            load_valid = 1'b1;
            load_data  = prog[i];
            load_last  = use_last && (i == prog.size() - 1);
            #1;
            check_value("beat_we", imem_we, 1'b1);
            check_value("beat_addr", imem_addr, i % DEPTH);
            check_value("beat_wdata", imem_wdata, prog[i]);
            ref_mem[i % DEPTH] = prog[i];
            @(negedge clock);
        end
        // First HOLD cycle: an extra beat must be refused.
        load_valid = 1'b1;
        load_data  = 32'h0BAD_0BAD;
        load_last  = 1'b0;
        #1;
        check_value("post_load_ready", load_ready, 1'b0);
        check_value("post_load_we", imem_we, 1'b0);
        load_valid = 1'b0;
    endtask

    // Called on a negedge in the first HOLD cycle; measures HOLD and RUN.
    task automatic run_check();
        int          hold_n = 0;
        int          run_n  = 0;
        logic [31:0] ec;
        logic        et;
        expected_run(ec, et);
        while (cpu_reset && hold_n < 1000) begin
            hold_n++;
            @(negedge clock);
        end
        check_value("hold_len", hold_n, RC);
        while (!halted && run_n < 5000) begin
            run_n++;
            @(negedge clock);
        end
        check_value("run_len", run_n, ec);
        check_value("cycle_count", cycle_count, ec);
        check_value("timeout", timeout, et);
        check_value("halt_cpu_reset", cpu_reset, 1'b1);
        check_value("halt_busy", busy, 1'b0);
    endtask

    initial begin
        int          wr_before;
        logic [31:0] w;
        reset      = 1'b1;
        start      = 1'b0;
        rerun      = 1'b0;
        load_valid = 1'b0;
        load_data  = 32'h0;
        load_last  = 1'b0;
        repeat (3) @(negedge clock);
        check_value("rst_cpu_reset", cpu_reset, 1'b1);
        check_value("rst_load_ready", load_ready, 1'b0);
        check_value("rst_imem_we", imem_we, 1'b0);
        check_value("rst_imem_addr", imem_addr, 0);
        check_value("rst_busy", busy, 1'b0);
        check_value("rst_halted", halted, 1'b0);
        check_value("rst_timeout", timeout, 1'b0);
        check_value("rst_cycle_count", cycle_count, 0);
        reset = 1'b0;

        // rerun in IDLE does nothing.
        @(negedge clock);
        rerun = 1'b1;
        @(negedge clock);
        rerun = 1'b0;
        #1;
        check_value("idle_rerun_busy", busy, 1'b0);
        check_value("idle_rerun_ready", load_ready, 1'b0);

        // Directed four-word program ending in the halt word.
        prog = '{32'h0050_0093, 32'h0010_0113, 32'h0020_81B3, 32'h0000_0000};
        load_program(1'b1, 1'b0, 1'b0);
        run_check();

        // rerun: no writes, same run.
        wr_before = n_writes;
        rerun = 1'b1;
        @(negedge clock);
        rerun = 1'b0;
        run_check();
        check_value("rerun_no_writes", n_writes, wr_before);

        // Random programs with random gaps; first one uses start+rerun together.
        for (int t = 0; t < 6; t++) begin
            prog.delete();
            for (int i = 0; i < $urandom_range(1, 40); i++) begin
                w = ($urandom_range(0, 5) == 0) ? 32'h0 : nz_word();
                prog.push_back(w);
            end
            if ($urandom_range(0, 1) == 1) prog.push_back(32'h0);
            load_program(1'b1, 1'b1, t == 0);
            run_check();
        end

        // Full-capacity load without load_last; single halt word at 200.
        prog.delete();
        for (int i = 0; i < DEPTH; i++) prog.push_back((i == 200) ? 32'h0 : nz_word());
        load_program(1'b0, 1'b0, 1'b0);
        run_check();

        // Halt word landing exactly on the watchdog limit.
        prog.delete();
        for (int i = 0; i < int'(WD) - 1; i++) prog.push_back(nz_word());
        prog.push_back(32'h0);
        load_program(1'b1, 1'b1, 1'b0);
        run_check();

        // Longer non-halting prefix than the watchdog limit.
        prog.delete();
        for (int i = 0; i < int'(WD) + 5; i++) prog.push_back(nz_word());
        load_program(1'b1, 1'b0, 1'b0);
        run_check();

        // Asynchronous reset in the middle of RUN.
        prog.delete();
        for (int i = 0; i < 10; i++) prog.push_back(nz_word());
        load_program(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 1000 && cpu_reset; i++) @(negedge clock);
        repeat (30) @(negedge clock);
        check_value("midrun_busy", busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        check_value("async_cpu_reset", cpu_reset, 1'b1);
        check_value("async_busy", busy, 1'b0);
        check_value("async_cycle_count", cycle_count, 0);
        check_value("async_halted", halted, 1'b0);
        check_value("async_load_ready", load_ready, 1'b0);
        @(negedge clock);
        reset = 1'b0;

        // Recovery after reset with the directed program.
        prog = '{32'h0050_0093, 32'h0010_0113, 32'h0020_81B3, 32'h0000_0000};
        load_program(1'b1, 1'b1, 1'b0);
        run_check();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
